// File: rtl/vs_spi_arbiter.sv
// Arbitrates the VS10xx serial bus between 32-bit SCI writes and 16-bit SDI words.
// Optional DREQ-wait watchdog is built when VS_DREQ_TIMEOUT_EN is defined.
module vs_spi_arbiter #(
  parameter int SCK_DIV = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_DREQ,
  input  logic        cmd_req,
  input  logic [31:0] cmd_word,
  output logic        cmd_ack,
  input  logic        dat_req,
  input  logic [15:0] dat_word,
  output logic        dat_ack,
  output logic        o_XCS,
  output logic        o_XDCS,
  output logic        o_SCK,
  output logic        o_SI,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, CMD_SHIFT, DAT_SHIFT, GAP} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(SCK_DIV - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  half_cnt_reg;
  logic [5:0]  half_idx_reg;
  logic [31:0] shift_reg;
  logic        half_done;
  logic [5:0]  last_half;

  assign half_done = (half_cnt_reg == DIV_LAST);
  assign last_half = (state_reg == CMD_SHIFT) ? 6'd63 : 6'd31;
  // The outgoing bit is always the top of the left-aligned shift register.
  assign o_SI = shift_reg[31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      half_idx_reg <= '0;
      shift_reg    <= '0;
      cmd_ack      <= 1'b0;
      dat_ack      <= 1'b0;
      o_XCS        <= 1'b1;
      o_XDCS       <= 1'b1;
      o_SCK        <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      dat_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          half_cnt_reg <= '0;
          half_idx_reg <= '0;
          if (i_DREQ && cmd_req) begin
            shift_reg <= cmd_word;
            o_XCS     <= 1'b0;
            cmd_ack   <= 1'b1;
            o_busy    <= 1'b1;
            state_reg <= CMD_SHIFT;
          end else if (i_DREQ && dat_req) begin
            shift_reg <= {dat_word, 16'h0000};
            o_XDCS    <= 1'b0;
            dat_ack   <= 1'b1;
            o_busy    <= 1'b1;
            state_reg <= DAT_SHIFT;
          end
        end
        CMD_SHIFT, DAT_SHIFT: begin
          if (half_done) begin
            half_cnt_reg <= '0;
            if (half_idx_reg == last_half) begin
              o_SCK     <= 1'b0;
              o_XCS     <= 1'b1;
              o_XDCS    <= 1'b1;
              state_reg <= GAP;
            end else begin
              half_idx_reg <= half_idx_reg + 6'd1;
              o_SCK        <= ~o_SCK;
              // Falling edge: advance to the next bit while SCK is low.
              if (o_SCK)
                shift_reg <= {shift_reg[30:0], 1'b0};
            end
          end else begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end
        end
        GAP: begin
          if (half_done) begin
            half_cnt_reg <= '0;
            o_busy       <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef VS_DREQ_TIMEOUT_EN
  logic [31:0] to_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
      o_timeout  <= 1'b0;
    end else if (state_reg == IDLE && (cmd_req || dat_req) && !i_DREQ) begin
      if (to_cnt_reg < TO_LAST)
        to_cnt_reg <= to_cnt_reg + 32'd1;
      else
        o_timeout <= 1'b1;
    end else begin
      to_cnt_reg <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vs_spi_arbiter.sv
// Bench for vs_spi_arbiter: timeline model checked every cycle, plus a bit scoreboard
// rebuilt from SCK rising edges and hand-computed latency/length expectations.
module tb_vs_spi_arbiter;
  localparam int D  = 2;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_DREQ = 1'b0;
  logic        cmd_req = 1'b0;
  logic [31:0] cmd_word = '0;
  logic        dat_req = 1'b0;
  logic [15:0] dat_word = '0;
  logic        cmd_ack, dat_ack, o_XCS, o_XDCS, o_SCK, o_SI, o_busy, o_timeout;

  vs_spi_arbiter #(.SCK_DIV(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_DREQ(i_DREQ),
    .cmd_req(cmd_req), .cmd_word(cmd_word), .cmd_ack(cmd_ack),
    .dat_req(dat_req), .dat_word(dat_word), .dat_ack(dat_ack),
    .o_XCS(o_XCS), .o_XDCS(o_XDCS), .o_SCK(o_SCK), .o_SI(o_SI),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  typedef struct { bit is_cmd; logic [31:0] w; } exp_t;
  exp_t exp_q[$];

  // Timeline model: a transfer is 2*bits*D cycles of shifting then D cycles of gap.
  bit m_busy = 0, m_cmd = 0, m_cack = 0, m_dack = 0, m_to = 0;
  int m_t = 0, m_pend = 0;
  logic [31:0] m_word = '0;

  function automatic int nbits(bit c);
    return c ? 32 : 16;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_cack = 0;
    m_dack = 0;
    if (!rst_n) begin
      m_busy = 0; m_t = 0; m_pend = 0; m_to = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 2 * nbits(m_cmd) * D + D) m_busy = 0;
    end else begin
      if ((cmd_req || dat_req) && !i_DREQ) begin
        m_pend++;
        if (m_pend >= TO) m_to = 1;
      end else begin
        m_pend = 0;
      end
      if (i_DREQ && cmd_req) begin
        m_busy = 1; m_cmd = 1; m_t = 0; m_word = cmd_word; m_cack = 1;
      end else if (i_DREQ && dat_req) begin
        m_busy = 1; m_cmd = 0; m_t = 0; m_word = {dat_word, 16'h0000}; m_dack = 1;
      end
    end
  end

  logic e_xcs, e_xdcs, e_sck, e_si, e_to;
  bit   sel;
  int   idx;

  always @(negedge clk) begin
    if (check_en) begin
      sel    = m_busy && (m_t < 2 * nbits(m_cmd) * D);
      e_xcs  = !(sel && m_cmd);
      e_xdcs = !(sel && !m_cmd);
      e_sck  = sel && (((m_t / D) % 2) == 1);
      idx    = sel ? 31 - m_t / (2 * D) : 31;
      e_si   = m_word[idx];
`ifdef VS_DREQ_TIMEOUT_EN
      e_to   = m_to;
`else
      e_to   = 1'b0;
`endif
      tests++;
      if (o_XCS !== e_xcs || o_XDCS !== e_xdcs || o_SCK !== e_sck || o_busy !== m_busy ||
          cmd_ack !== m_cack || dat_ack !== m_dack || o_timeout !== e_to ||
          (sel && o_SI !== e_si) || (!o_XCS && !o_XDCS)) begin
        fails++;
        $display("FAIL cycle %0d: xcs/xdcs/sck/si/busy/cack/dack/to got %b%b%b%b%b%b%b%b want %b%b%b%b%b%b%b%b",
                 cyc, o_XCS, o_XDCS, o_SCK, o_SI, o_busy, cmd_ack, dat_ack, o_timeout,
                 e_xcs, e_xdcs, e_sck, sel ? e_si : o_SI, m_busy, m_cack, m_dack, e_to);
      end
    end
  end

  // Scoreboard: reassemble words from the bits present at each SCK rising edge.
  logic prev_sck = 1'b0, prev_xcs = 1'b1, prev_xdcs = 1'b1;
  logic [31:0] acc = '0;
  int   bitcnt = 0, xcs_run = 0, last_xcs_run = 0;
  bit   rst_drop = 0;
  exp_t ex;

  always @(posedge clk) if (!rst_n) rst_drop = 1;

  always @(negedge clk) begin
    if ((!o_XCS && prev_xcs) || (!o_XDCS && prev_xdcs)) begin
      rst_drop = 0; bitcnt = 0; acc = '0;
    end
    if (!o_XCS) xcs_run++;
    if (o_SCK && !prev_sck) begin
      acc = {acc[30:0], o_SI};
      bitcnt++;
    end
    if ((o_XCS && !prev_xcs) || (o_XDCS && !prev_xdcs)) begin
      if (o_XCS && !prev_xcs) begin
        last_xcs_run = xcs_run;
        xcs_run = 0;
      end
      if (!rst_drop) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got word %h (%0d bits), want none", acc, bitcnt);
        end else begin
          ex = exp_q.pop_front();
          if (ex.is_cmd != !prev_xcs || bitcnt != nbits(ex.is_cmd) ||
              acc[15:0] != (ex.is_cmd ? ex.w[15:0] : ex.w[31:16]) ||
              (ex.is_cmd && acc[31:16] != ex.w[31:16])) begin
            fails++;
            $display("FAIL sb_word: got %h (%0d bits, cmd=%0d), want %h (cmd=%0d)",
                     acc, bitcnt, !prev_xcs, ex.w, ex.is_cmd);
          end
        end
      end
      xcs_run = 0;
    end
    prev_sck  = o_SCK;
    prev_xcs  = o_XCS;
    prev_xdcs = o_XDCS;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic wait_ack(input bit c, input string name, output int t);
    t = -1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (c ? cmd_ack : dat_ack) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      tests++; fails++;
      $display("FAIL %s: got no ack within 500 cycles, want ack", name);
    end
  endtask

  task automatic wait_idle(input string name, output int t);
    t = -1;
    for (int i = 0; i < 500; i++) begin
      if (!o_busy) begin
        t = cyc;
        break;
      end
      tick(1);
    end
    if (t < 0) begin
      tests++; fails++;
      $display("FAIL %s: got busy after 500 cycles, want idle", name);
    end
  endtask

  int t0, ta, tb2, ti;
  int acks[4];
  logic [15:0] words[4];

  initial begin
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hA5A5; words[3] = 16'h5A5A;
    tick(1);
    check_en = 1'b1;
    tick(2);
    check("rst_xcs", o_XCS, 1);
    check("rst_xdcs", o_XDCS, 1);
    check("rst_sck", o_SCK, 0);
    check("rst_si", o_SI, 0);
    check("rst_busy", o_busy, 0);
    check("rst_acks", cmd_ack + dat_ack, 0);
    check("rst_timeout", o_timeout, 0);
    rst_n = 1'b1;
    i_DREQ = 1'b1;
    tick(2);

    // Single SCI write.
    exp_q.push_back('{1'b1, 32'h020B2020});
    cmd_word = 32'h020B2020; cmd_req = 1'b1; t0 = cyc;
    wait_ack(1, "cmd_ack", ta);
    cmd_req = 1'b0;
    check("cmd_ack_latency", ta - t0, 1);
    wait_idle("cmd_idle", ti);
    check("cmd_busy_len", ti - ta, 65 * D);
    check("cmd_xcs_low", last_xcs_run, 64 * D);
    $display("[TB] cmd 020B2020 ack@%0d idle@%0d xcs_low=%0d", ta, ti, last_xcs_run);
    tick(2);

    // Simultaneous requests: command wins.
    exp_q.push_back('{1'b1, 32'h02000800});
    exp_q.push_back('{1'b0, 32'hFFFB0000});
    cmd_word = 32'h02000800; dat_word = 16'hFFFB;
    cmd_req = 1'b1; dat_req = 1'b1;
    wait_ack(1, "prio_cmd_ack", ta);
    cmd_req = 1'b0;
    wait_ack(0, "prio_dat_ack", tb2);
    dat_req = 1'b0;
    check("prio_gap", tb2 - ta, 1 + 65 * D);
    $display("[TB] prio cmd ack@%0d dat ack@%0d", ta, tb2);
    wait_idle("prio_idle", ti);
    tick(2);

    // DREQ gating; a started word ignores DREQ.
    i_DREQ = 1'b0;
    exp_q.push_back('{1'b0, 32'h12340000});
    dat_word = 16'h1234; dat_req = 1'b1;
    tick(10);
    check("dreq_low_busy", o_busy, 0);
    i_DREQ = 1'b1; t0 = cyc;
    wait_ack(0, "dreq_ack", ta);
    dat_req = 1'b0;
    check("dreq_ack_latency", ta - t0, 1);
    tick(6);
    i_DREQ = 1'b0;
    wait_idle("dreq_idle", ti);
    check("dreq_word_len", ti - ta, 33 * D);
    $display("[TB] dreq-gated dat 1234 ack@%0d idle@%0d", ta, ti);
    i_DREQ = 1'b1;
    tick(2);

    // Reset at bit 20 of a command; the held request is re-acked.
    exp_q.push_back('{1'b1, 32'h020BAA55});
    cmd_word = 32'h020BAA55; cmd_req = 1'b1;
    wait_ack(1, "rstmid_ack", ta);
    tick(20 * 2 * D);
    rst_n = 1'b0;
    tick(1);
    check("rstmid_xcs", o_XCS, 1);
    check("rstmid_sck", o_SCK, 0);
    check("rstmid_busy", o_busy, 0);
    rst_n = 1'b1; t0 = cyc;
    wait_ack(1, "rstmid_reack", tb2);
    cmd_req = 1'b0;
    check("rstmid_reack_latency", tb2 - t0, 1);
    $display("[TB] reset mid-cmd ack@%0d reack@%0d", ta, tb2);
    wait_idle("rstmid_idle", ti);
    tick(2);

    // Back-to-back data stream.
    foreach (words[i]) exp_q.push_back('{1'b0, {words[i], 16'h0000}});
    dat_word = words[0]; dat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, "stream_ack", acks[i]);
      if (i < 3) dat_word = words[i + 1];
      else dat_req = 1'b0;
      $display("[TB] stream word %h ack@%0d", words[i], acks[i]);
    end
    for (int i = 1; i < 4; i++) check("stream_period", acks[i] - acks[i - 1], 1 + 33 * D);
    wait_idle("stream_idle", ti);
    tick(2);

    // Withdrawn request is never sent.
    i_DREQ = 1'b0; dat_word = 16'hDEAD; dat_req = 1'b1;
    tick(3);
    dat_req = 1'b0; i_DREQ = 1'b1;
    tick(5);
    check("withdraw_busy", o_busy, 0);
    $display("[TB] withdrawn dat request, busy=%0d", o_busy);

    // DREQ watchdog.
    i_DREQ = 1'b0;
    exp_q.push_back('{1'b1, 32'h02000004});
    cmd_word = 32'h02000004; cmd_req = 1'b1; t0 = cyc; ti = -1;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (o_timeout && ti < 0) ti = cyc;
    end
`ifdef VS_DREQ_TIMEOUT_EN
    check("timeout_rise", ti - t0, TO);
`else
    check("timeout_absent", o_timeout, 0);
`endif
    check("timeout_busy", o_busy, 0);
    i_DREQ = 1'b1;
    wait_ack(1, "timeout_ack", ta);
    cmd_req = 1'b0;
    wait_idle("timeout_idle", ti);
`ifdef VS_DREQ_TIMEOUT_EN
    check("timeout_sticky", o_timeout, 1);
`endif
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("timeout_cleared", o_timeout, 0);
    $display("[TB] dreq watchdog cmd ack@%0d timeout=%0d", ta, o_timeout);
    tick(3);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
